alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_pkg.sv | 49 ++++
 rtl/alu_muldiv_if.sv | 26 ++
 rtl/alu_muldiv.sv | 157 +++++++++++++++
 tb/tb_alu_muldiv.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared constants for the integer execution units: ALU op codes plus the
// multiply/divide op encodings and FSM state used by alu_muldiv.
package alu_muldiv_pkg;

  localparam int ALU_OP_WIDTH = 4;
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam int MD_OP_WIDTH = 3;
  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_a_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result handshake between the issue stage and the multiply/divide unit.
interface alu_muldiv_if
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  md_op_e          op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction at the end.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input logic        clk,
  input logic        rst,
  alu_muldiv_if.slave md
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r;
  md_op_e          op_r;
  logic            neg_r;
  logic [XLEN-1:0] hi_r, lo_r, opnd_r, out_r;

  logic            accept_s, a_neg_s, b_neg_s, b_zero_s, ovf_s, fast_s, neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, fast_res_s, final_s, quo_s, rem_s;
  logic [XLEN:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0] prod_s;
  logic            in_ready_s, out_valid_s;

  // Request decode: magnitudes, result sign and early-out detection.
  always_comb begin
    accept_s = md.in_valid && (state_r == MD_IDLE) && !md.flush;
    a_neg_s  = md_a_signed(md.op) && md.a[XLEN-1];
    b_neg_s  = md_b_signed(md.op) && md.b[XLEN-1];
    a_mag_s  = a_neg_s ? -md.a : md.a;
    b_mag_s  = b_neg_s ? -md.b : md.b;
    b_zero_s = (md.b == {XLEN{1'b0}});
    ovf_s    = (md.op inside {MD_DIV, MD_REM}) && (md.a == MOST_NEG) && (md.b == {XLEN{1'b1}});
    fast_s   = FAST_ZERO && md_is_div(md.op) && (b_zero_s || ovf_s);
    // A zero divisor must leave the all-ones quotient uncorrected.
    if (md.op inside {MD_REM, MD_REMU}) begin
      neg_s = a_neg_s;
    end else if (md_is_div(md.op)) begin
      neg_s = (a_neg_s ^ b_neg_s) && !b_zero_s;
    end else begin
      neg_s = a_neg_s ^ b_neg_s;
    end
    case (md.op)
      MD_DIV, MD_DIVU: fast_res_s = b_zero_s ? {XLEN{1'b1}} : md.a;
      MD_REM, MD_REMU: fast_res_s = b_zero_s ? md.a : {XLEN{1'b0}};
      default:         fast_res_s = {XLEN{1'b0}};
    endcase
  end

  // One iteration step and final sign-corrected result selection.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_shift_s = {hi_r, lo_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    prod_s      = neg_r ? -{hi_r, lo_r} : {hi_r, lo_r};
    quo_s       = neg_r ? -lo_r : lo_r;
    rem_s       = neg_r ? -hi_r : hi_r;
    case (op_r)
      MD_MUL:                       final_s = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_s = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_s = quo_s;
      MD_REM, MD_REMU:              final_s = rem_s;
      default:                      final_s = {XLEN{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush wins over every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (md.flush) begin
      state_nxt_s = MD_IDLE;
    end else begin
      case (state_r)
        MD_IDLE: if (md.in_valid) state_nxt_s = fast_s ? MD_DONE : MD_CALC;
                 else              state_nxt_s = MD_IDLE;
        MD_CALC: if (cnt_r == CNT_LAST) state_nxt_s = MD_DONE;
                 else                   state_nxt_s = MD_CALC;
        MD_DONE: if (md.out_ready) state_nxt_s = MD_IDLE;
                 else              state_nxt_s = MD_DONE;
        default: state_nxt_s = MD_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    in_ready_s  = (state_r == MD_IDLE);
    out_valid_s = (state_r == MD_DONE);
  end

  // Datapath: capture on accept, XLEN iterations, then one finalize cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      op_r   <= MD_MUL;
      neg_r  <= 1'b0;
      hi_r   <= {XLEN{1'b0}};
      lo_r   <= {XLEN{1'b0}};
      opnd_r <= {XLEN{1'b0}};
      out_r  <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (accept_s) begin
            op_r   <= md.op;
            neg_r  <= neg_s;
            cnt_r  <= {CW{1'b0}};
            hi_r   <= {XLEN{1'b0}};
            lo_r   <= md_is_div(md.op) ? a_mag_s : b_mag_s;
            opnd_r <= md_is_div(md.op) ? b_mag_s : a_mag_s;
            if (fast_s) out_r <= fast_res_s;
          end
        end
        MD_CALC: begin
          if (cnt_r == CNT_LAST) begin
            out_r <= final_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
            if (md_is_div(op_r)) begin
              if (!div_diff_s[XLEN]) begin
                hi_r <= div_diff_s[XLEN-1:0];
                lo_r <= {lo_r[XLEN-2:0], 1'b1};
              end else begin
                hi_r <= div_shift_s[XLEN-1:0];
                lo_r <= {lo_r[XLEN-2:0], 1'b0};
              end
            end else begin
              {hi_r, lo_r} <= {mul_sum_s, lo_r[XLEN-1:1]};
            end
          end
        end
        default: begin
          out_r <= out_r;
        end
      endcase
    end
  end

  assign md.in_ready  = in_ready_s;
  assign md.out_valid = out_valid_s;
  assign md.out       = out_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: 32-bit fast, 64-bit fast and 32-bit
// non-fast instances driven from one shared operand bus.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv = 3'b000;
  md_op_e      op_d = MD_MUL;
  logic [63:0] a_d = 64'd0;
  logic [63:0] b_d = 64'd0;
  logic        flush_d = 1'b0;
  logic        ordy_d = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          lat;
  int          rises;

  always #5 clk = ~clk;

  alu_muldiv_if #(.XLEN(32)) if32 ();
  alu_muldiv_if #(.XLEN(64)) if64 ();
  alu_muldiv_if #(.XLEN(32)) ifnz ();

  assign if32.in_valid = iv[0];
  assign if64.in_valid = iv[1];
  assign ifnz.in_valid = iv[2];
  assign if32.op = op_d;
  assign if64.op = op_d;
  assign ifnz.op = op_d;
  assign if32.a = a_d[31:0];
  assign if32.b = b_d[31:0];
  assign if64.a = a_d;
  assign if64.b = b_d;
  assign ifnz.a = a_d[31:0];
  assign ifnz.b = b_d[31:0];
  assign if32.flush = flush_d;
  assign if64.flush = flush_d;
  assign ifnz.flush = flush_d;
  assign if32.out_ready = ordy_d;
  assign if64.out_ready = ordy_d;
  assign ifnz.out_ready = ordy_d;

  alu_muldiv #(.XLEN(32), .FAST_ZERO(1'b1)) u32 (.clk(clk), .rst(rst), .md(if32));
  alu_muldiv #(.XLEN(64), .FAST_ZERO(1'b1)) u64 (.clk(clk), .rst(rst), .md(if64));
  alu_muldiv #(.XLEN(32), .FAST_ZERO(1'b0)) unz (.clk(clk), .rst(rst), .md(ifnz));

  function automatic logic [63:0] get_out(input int sel);
    case (sel)
      0:       return {32'd0, if32.out};
      1:       return if64.out;
      default: return {32'd0, ifnz.out};
    endcase
  endfunction

  function automatic logic get_ov(input int sel);
    case (sel)
      0:       return if32.out_valid;
      1:       return if64.out_valid;
      default: return ifnz.out_valid;
    endcase
  endfunction

  function automatic logic get_rdy(input int sel);
    case (sel)
      0:       return if32.in_ready;
      1:       return if64.in_ready;
      default: return ifnz.in_ready;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then scramble the bus to prove operands were captured.
  task automatic start(input int sel, input md_op_e o, input logic [63:0] av, input logic [63:0] bv);
    int n = 0;
    while (!get_rdy(sel) && n < 200) begin
      tick();
      n++;
    end
    chk("ready_before_issue", {63'd0, get_rdy(sel)}, 64'd1);
    op_d = o;
    a_d = av;
    b_d = bv;
    iv[sel] = 1'b1;
    tick();
    iv[sel] = 1'b0;
    a_d = ~av;
    b_d = ~bv;
    op_d = MD_MULHU;
  endtask

  // Edges after the accept edge until out_valid is seen (0 = next cycle).
  task automatic wait_result(input int sel, output int l);
    l = 0;
    while (!get_ov(sel) && l < 200) begin
      tick();
      l++;
    end
  endtask

  task automatic take(input int sel);
    ordy_d = 1'b1;
    tick();
    ordy_d = 1'b0;
    chk("ov_low_after_take", {63'd0, get_ov(sel)}, 64'd0);
    chk("ready_after_take", {63'd0, get_rdy(sel)}, 64'd1);
  endtask

  task automatic op_test(input string tag, input int sel, input md_op_e o, input logic [63:0] av,
                         input logic [63:0] bv, input logic [63:0] exp, input int exp_lat);
    int l;
    start(sel, o, av, bv);
    wait_result(sel, l);
    chk({tag, "_out"}, get_out(sel), exp);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
    take(sel);
  endtask

  task automatic count_rises(input int sel, input int cycles, output int r);
    r = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (get_ov(sel)) r++;
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out", get_out(0), 64'd0);
    chk("rst_ov", {63'd0, get_ov(0)}, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", {63'd0, get_rdy(0)}, 64'd1);

    // Nominal result appears XLEN+1 edges after the accept edge.
    op_test("mul_7_m3", 0, MD_MUL, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 33);
    op_test("mulhu_max", 0, MD_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33);
    op_test("mulhsu_m1", 0, MD_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 33);
    op_test("mulh_neg", 0, MD_MULH, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33);
    op_test("div_m7_2", 0, MD_DIV, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33);
    op_test("rem_m7_2", 0, MD_REM, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 33);
    op_test("divu_100_7", 0, MD_DIVU, 64'd100, 64'd7, 64'd14, 33);
    op_test("remu_100_7", 0, MD_REMU, 64'd100, 64'd7, 64'd2, 33);
    // Early-out: result visible in the cycle right after the accept cycle.
    op_test("divu_by0_fast", 0, MD_DIVU, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF, 0);
    op_test("rem_ovf_fast", 0, MD_REM, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 0);
    op_test("div_ovf_fast", 0, MD_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0);
    op_test("rem_by0_fast", 0, MD_REM, 64'hFFFF_FFF9, 64'h0, 64'hFFFF_FFF9, 0);
    // Same corner cases without the early-out take the full iteration path.
    op_test("div_by0_slow", 2, MD_DIV, 64'hFFFF_FFF9, 64'h0, 64'hFFFF_FFFF, 33);
    op_test("rem_by0_slow", 2, MD_REM, 64'hFFFF_FFF9, 64'h0, 64'hFFFF_FFF9, 33);
    op_test("div_ovf_slow", 2, MD_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 33);

    // Result held while the consumer stalls; no bypass accept on the take edge.
    start(0, MD_MUL, 64'd12, 64'd11);
    wait_result(0, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ov", {63'd0, get_ov(0)}, 64'd1);
      chk("hold_out", get_out(0), 64'd132);
      chk("hold_ready", {63'd0, get_rdy(0)}, 64'd0);
    end
    op_d = MD_MUL;
    a_d = 64'd3;
    b_d = 64'd5;
    iv[0] = 1'b1;
    ordy_d = 1'b1;
    tick();
    ordy_d = 1'b0;
    chk("no_bypass_accept", {63'd0, get_rdy(0)}, 64'd1);
    tick();
    iv[0] = 1'b0;
    chk("accept_after_take", {63'd0, get_rdy(0)}, 64'd0);
    wait_result(0, lat);
    chk("after_take_out", get_out(0), 64'd15);
    chk("after_take_lat", 64'(lat), 64'd33);
    take(0);

    // Flush in IDLE with a request present must not accept.
    flush_d = 1'b1;
    iv[0] = 1'b1;
    tick();
    flush_d = 1'b0;
    iv[0] = 1'b0;
    chk("flush_idle_no_accept", {63'd0, get_rdy(0)}, 64'd1);

    // Flush mid-calculation drops the operation.
    start(0, MD_MUL, 64'd9, 64'd9);
    for (int i = 0; i < 10; i++) tick();
    flush_d = 1'b1;
    tick();
    flush_d = 1'b0;
    chk("flush_ready", {63'd0, get_rdy(0)}, 64'd1);
    chk("flush_ov", {63'd0, get_ov(0)}, 64'd0);
    count_rises(0, 50, rises);
    chk("flush_no_result", 64'(rises), 64'd0);
    op_test("div_after_flush", 0, MD_DIV, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33);

    // Reset while a result waits in DONE.
    start(0, MD_MUL, 64'd7, 64'hFFFF_FFFD);
    wait_result(0, lat);
    chk("pre_rst_ov", {63'd0, get_ov(0)}, 64'd1);
    rst = 1'b1;
    ordy_d = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_done_ov", {63'd0, get_ov(0)}, 64'd0);
    chk("rst_done_out", get_out(0), 64'd0);
    chk("rst_done_ready", {63'd0, get_rdy(0)}, 64'd1);
    count_rises(0, 40, rises);
    chk("rst_done_no_result", 64'(rises), 64'd0);

    // Reset mid-calculation on the 64-bit unit, then the 64-bit latency case.
    start(1, MD_MUL, 64'd5, 64'd5);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_rises(1, 80, rises);
    chk("rst_calc_no_result", 64'(rises), 64'd0);
    op_test("mul64_7_m3", 1, MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    op_test("mulhu64_max", 1, MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
